// File: rtl/pdp8_bin_defs_pkg.sv
// Shared definitions for the PDP-8 BIN paper-tape loader.
//   state_e       : loader FSM states
//   frame_cls_e   : frame classes produced by pdp8_bin_frame_decode
//   *_FRAME/FIELD : frame-class constants
//   frame_pair_sum: raw tape-frame sum of a data word's two frames
package pdp8_bin_defs;

    typedef enum logic [2:0] {
        StIdle,
        StLeader,
        StHi,
        StLo,
        StWrite,
        StEnd
    } state_e;

    typedef enum logic [2:0] {
        ClsIgnore,
        ClsLeader,
        ClsRubout,
        ClsField,
        ClsOrigin,
        ClsData
    } frame_cls_e;

    localparam logic [7:0] LEADER_FRAME = 8'o200;
    localparam logic [7:0] RUBOUT_FRAME = 8'o377;
    localparam logic [7:0] FIELD_MASK   = 8'o307;
    localparam logic [7:0] FIELD_MATCH  = 8'o300;

    // A data word arrives as {00,hi6} and {00,lo6}, so its frames add to hi6 + lo6.
    function automatic logic [11:0] frame_pair_sum(input logic [11:0] word);
        return {6'd0, word[11:6]} + {6'd0, word[5:0]};
    endfunction

endpackage

// File: rtl/pdp8_bin_frame_decode.sv
// Combinational BIN tape-frame classifier.
//   frame   in  8 : raw tape frame
//   cls     out   : frame class (leader, rubout, field, origin, data, ignore)
//   payload out 6 : low six bits of the frame (field number sits in [5:3])
module pdp8_bin_frame_decode
    import pdp8_bin_defs::*;
(
    input  logic [7:0] frame,
    output frame_cls_e cls,
    output logic [5:0] payload
);

    always_comb begin
        payload = frame[5:0];
        if (frame == RUBOUT_FRAME) begin
            cls = ClsRubout;
        end else if (frame == LEADER_FRAME) begin
            cls = ClsLeader;
        end else if ((frame & FIELD_MASK) == FIELD_MATCH) begin
            cls = ClsField;
        end else if (frame[7:6] == 2'b01) begin
            cls = ClsOrigin;
        end else if (frame[7:6] == 2'b00) begin
            cls = ClsData;
        end else begin
            cls = ClsIgnore;
        end
    end

endmodule

// File: rtl/pdp8_bin_loader.sv
// PDP-8 BIN-format paper-tape loader feeding 32Kx12 memory.
//   clk, reset (async, active-high), enable (level)
//   rx_data/rx_valid/rx_ready : tape frame stream from the UART
//   ext_ram_write_req/ma/out/done : word write handshake, req held until done
//   busy, done, cksum_ok, err, words_loaded : load status
module pdp8_bin_loader
    import pdp8_bin_defs::*;
#(
    parameter int unsigned LEADER_MIN = 8,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        ext_ram_write_req,
    output logic [14:0] ext_ram_ma,
    output logic [11:0] ext_ram_out,
    input  logic        ext_ram_done,
    output logic        busy,
    output logic        done,
    output logic        cksum_ok,
    output logic        err,
    output logic [14:0] words_loaded
);

    localparam int unsigned LcW = (LEADER_MIN > 1) ? $clog2(LEADER_MIN) : 1;
    localparam int unsigned TmW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e      state_q, state_d;
    logic [LcW-1:0] lead_cnt_q, lead_cnt_d;
    logic [TmW-1:0] tmo_q, tmo_d;
    logic        skip_q, skip_d;
    logic [2:0]  field_q, field_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] sum_q, sum_d;
    logic [5:0]  hi_q, hi_d;
    logic        hi_org_q, hi_org_d;
    logic        pend_valid_q, pend_valid_d;
    logic [11:0] pend_word_q, pend_word_d;
    logic [14:0] pend_ma_q, pend_ma_d;
    logic [14:0] wr_ma_q, wr_ma_d;
    logic [11:0] wr_data_q, wr_data_d;
    logic [14:0] words_q, words_d;
    logic        cksum_q, cksum_d;
    logic        err_q, err_d;

    frame_cls_e  cls;
    logic [5:0]  payload;
    logic        accept;
    logic        loading;
    logic        tmo_hit;
    logic [11:0] word;

    pdp8_bin_frame_decode u_decode (
        .frame   (rx_data),
        .cls     (cls),
        .payload (payload)
    );

    assign rx_ready = enable && !reset && (state_q != StWrite) && (state_q != StEnd);
    assign accept   = rx_valid && rx_ready;
    assign loading  = (state_q == StLeader) || (state_q == StHi) || (state_q == StLo);
    assign word     = {hi_q, payload};

    assign ext_ram_write_req = (state_q == StWrite);
    assign ext_ram_ma        = wr_ma_q;
    assign ext_ram_out       = wr_data_q;
    assign busy              = loading || (state_q == StWrite);
    assign done              = (state_q == StEnd);
    assign cksum_ok          = cksum_q;
    assign err               = err_q;
    assign words_loaded      = words_q;

    always_comb begin
        state_d      = state_q;
        lead_cnt_d   = lead_cnt_q;
        skip_d       = skip_q;
        field_d      = field_q;
        addr_d       = addr_q;
        sum_d        = sum_q;
        hi_d         = hi_q;
        hi_org_d     = hi_org_q;
        pend_valid_d = pend_valid_q;
        pend_word_d  = pend_word_q;
        pend_ma_d    = pend_ma_q;
        wr_ma_d      = wr_ma_q;
        wr_data_d    = wr_data_q;
        words_d      = words_q;
        cksum_d      = cksum_q;
        err_d        = err_q;
        tmo_d        = '0;
        tmo_hit      = 1'b0;

        if (loading && !accept && (TIMEOUT != 0)) begin
            tmo_d   = tmo_q + 1'b1;
            tmo_hit = (tmo_d == TmW'(TIMEOUT));
        end

        unique case (state_q)
            StIdle: begin
                if (!enable) begin
                    lead_cnt_d = '0;
                    skip_d     = 1'b0;
                end else if (accept) begin
                    if (cls == ClsRubout) begin
                        skip_d     = !skip_q;
                        lead_cnt_d = '0;
                    end else if (!skip_q) begin
                        if (cls != ClsLeader) begin
                            lead_cnt_d = '0;
                        end else if (lead_cnt_q == LcW'(LEADER_MIN - 1)) begin
                            // Armed: start a fresh load context.
                            state_d      = StLeader;
                            lead_cnt_d   = '0;
                            field_d      = '0;
                            addr_d       = '0;
                            sum_d        = '0;
                            pend_valid_d = 1'b0;
                            words_d      = '0;
                            cksum_d      = 1'b0;
                        end else begin
                            lead_cnt_d = lead_cnt_q + 1'b1;
                        end
                    end
                end
            end

            StLeader, StHi, StLo: begin
                if (!enable) begin
                    state_d = StIdle;
                    skip_d  = 1'b0;
                end else if (accept) begin
                    if (cls == ClsRubout) begin
                        skip_d = !skip_q;
                    end else if (!skip_q) begin
                        if (cls == ClsField) begin
                            field_d = payload[5:3];
                        end else if ((state_q != StLo) &&
                                     ((cls == ClsOrigin) || (cls == ClsData))) begin
                            hi_d     = payload;
                            hi_org_d = (cls == ClsOrigin);
                            sum_d    = sum_q + {4'd0, rx_data};
                            state_d  = StLo;
                        end else if ((state_q == StHi) && (cls == ClsLeader)) begin
                            // Trailer: the pending word is the checksum, never written.
                            state_d      = StEnd;
                            pend_valid_d = 1'b0;
                            if (pend_valid_q) begin
                                cksum_d = ((sum_q - frame_pair_sum(pend_word_q)) == pend_word_q);
                            end else begin
                                cksum_d = 1'b0;
                                err_d   = 1'b1;
                            end
                        end else if ((state_q == StLo) && (cls == ClsData)) begin
                            sum_d = sum_q + {4'd0, rx_data};
                            if (hi_org_q) begin
                                addr_d  = word;
                                state_d = StHi;
                            end else begin
                                // Address and field are bound when the word is captured.
                                pend_word_d  = word;
                                pend_ma_d    = {field_q, addr_q};
                                addr_d       = addr_q + 12'd1;
                                pend_valid_d = 1'b1;
                                if (pend_valid_q) begin
                                    wr_ma_d   = pend_ma_q;
                                    wr_data_d = pend_word_q;
                                    state_d   = StWrite;
                                end else begin
                                    state_d = StHi;
                                end
                            end
                        end
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StEnd;
                end
            end

            StWrite: begin
                if (ext_ram_done) begin
                    words_d = words_q + 15'd1;
                    state_d = StHi;
                end
            end

            StEnd: begin
                if (!enable) begin
                    state_d = StIdle;
                    cksum_d = 1'b0;
                    skip_d  = 1'b0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            lead_cnt_q   <= '0;
            tmo_q        <= '0;
            skip_q       <= 1'b0;
            field_q      <= '0;
            addr_q       <= '0;
            sum_q        <= '0;
            hi_q         <= '0;
            hi_org_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            pend_ma_q    <= '0;
            wr_ma_q      <= '0;
            wr_data_q    <= '0;
            words_q      <= '0;
            cksum_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lead_cnt_q   <= lead_cnt_d;
            tmo_q        <= tmo_d;
            skip_q       <= skip_d;
            field_q      <= field_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            hi_q         <= hi_d;
            hi_org_q     <= hi_org_d;
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= pend_word_d;
            pend_ma_q    <= pend_ma_d;
            wr_ma_q      <= wr_ma_d;
            wr_data_q    <= wr_data_d;
            words_q      <= words_d;
            cksum_q      <= cksum_d;
            err_q        <= err_d;
        end
    end

endmodule
